// File: rtl/gshare_predictor_pkg.sv
// gshare_predictor_pkg
// Shared types and helpers for the branch predictor:
//   pcnext_sel_e  - encoding of the Fetch PCnext MUX select
//   ctr_init      - reset value of a saturating counter (weakly not-taken)
//   ctr_max       - saturation ceiling of a counter of a given width
//   ctr_sat_step  - one saturating increment/decrement step
// Counters are handled here at the widest supported width (4 bits).
// Callers cast to and from their own CTR_WIDTH.
package gshare_predictor_pkg;

    typedef enum logic [1:0] {
        PC4_IF    = 2'b00,
        PC4_EXMEM = 2'b01,
        BTB_TGT   = 2'b10,
        BR_TGT    = 2'b11
    } pcnext_sel_e;

    localparam int CTR_MAX_WIDTH = 4;
    typedef logic [CTR_MAX_WIDTH-1:0] ctr_t;

    function automatic ctr_t ctr_init(input int ctr_width);
        return ctr_t'((1 << (ctr_width - 1)) - 1);
    endfunction

    function automatic ctr_t ctr_max(input int ctr_width);
        return ctr_t'((1 << ctr_width) - 1);
    endfunction

    function automatic ctr_t ctr_sat_step(input ctr_t ctr, input logic up, input int ctr_width);
        ctr_t result;
        result = ctr;
        if (up) begin
            if (ctr < ctr_max(ctr_width)) begin
                result = ctr + ctr_t'(1);
            end
        end else if (ctr != '0) begin
            result = ctr - ctr_t'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// gshare_predictor_if
// Fetch-side lookup and commit-side (EXMEM) update signals of the predictor.
//   master : pipeline side, drives IF lookup and EXMEM commit fields
//   slave  : predictor side, returns hit/prediction/target and PCnext control
interface gshare_predictor_if #(
    parameter int INDEX_WIDTH = 12
);
    localparam int TAG_W = 32 - INDEX_WIDTH - 2;

    // Fetch lookup
    logic [TAG_W-1:0]       IF_PC_tag;
    logic [INDEX_WIDTH-1:0] IF_btb_rd_index;

    // Commit stage
    logic                   EXMEM_valid;
    logic                   EXMEM_is_jmp;
    logic                   EXMEM_is_uncond;
    logic                   EXMEM_br_decision;
    logic [INDEX_WIDTH-1:0] EXMEM_btb_wr_index;
    logic [TAG_W-1:0]       EXMEM_btb_wr_tag;
    logic [31:0]            EXMEM_btb_wr_target;
    logic                   EXMEM_pred_taken;
    logic [31:0]            EXMEM_pred_target;
    logic [INDEX_WIDTH-1:0] EXMEM_pht_index;

    // Predictor results
    logic                   IF_btb_hit;
    logic                   IF_pred_taken;
    logic [INDEX_WIDTH-1:0] IF_pht_index;
    logic [31:0]            IF_btb_rd_target;
    logic [1:0]             IF_PCnext_sel;
    logic                   IF_flush;

    modport master (
        output IF_PC_tag, IF_btb_rd_index,
        output EXMEM_valid, EXMEM_is_jmp, EXMEM_is_uncond, EXMEM_br_decision,
        output EXMEM_btb_wr_index, EXMEM_btb_wr_tag, EXMEM_btb_wr_target,
        output EXMEM_pred_taken, EXMEM_pred_target, EXMEM_pht_index,
        input  IF_btb_hit, IF_pred_taken, IF_pht_index, IF_btb_rd_target,
        input  IF_PCnext_sel, IF_flush
    );

    modport slave (
        input  IF_PC_tag, IF_btb_rd_index,
        input  EXMEM_valid, EXMEM_is_jmp, EXMEM_is_uncond, EXMEM_br_decision,
        input  EXMEM_btb_wr_index, EXMEM_btb_wr_tag, EXMEM_btb_wr_target,
        input  EXMEM_pred_taken, EXMEM_pred_target, EXMEM_pht_index,
        output IF_btb_hit, IF_pred_taken, IF_pht_index, IF_btb_rd_target,
        output IF_PCnext_sel, IF_flush
    );

endinterface

// File: rtl/gshare_predictor_btb.sv
// gshare_predictor_btb
// Tagged, direct-mapped branch target buffer with a per-entry unconditional bit.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset (clears valid bits)
//   rd_index_i, rd_tag_i   combinational lookup
//   rd_hit_o               entry valid and tag match
//   rd_uncond_o            stored entry is JAL/JALR
//   rd_target_o            stored target
//   wr_en_i, wr_*_i        write of tag/target/uncond; sets valid
// Reads see the pre-write contents in the cycle of a write (no bypass).
module gshare_predictor_btb #(
    parameter int INDEX_WIDTH = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [INDEX_WIDTH-1:0]        rd_index_i,
    input  logic [32-INDEX_WIDTH-2-1:0]   rd_tag_i,
    output logic                          rd_hit_o,
    output logic                          rd_uncond_o,
    output logic [31:0]                   rd_target_o,
    input  logic                          wr_en_i,
    input  logic [INDEX_WIDTH-1:0]        wr_index_i,
    input  logic [32-INDEX_WIDTH-2-1:0]   wr_tag_i,
    input  logic [31:0]                   wr_target_i,
    input  logic                          wr_uncond_i
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TAG_W   = 32 - INDEX_WIDTH - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;

    // Payload needs no reset: it is only trusted behind a valid bit.
    logic [TAG_W-1:0] tag_mem    [ENTRIES];
    logic [31:0]      target_mem [ENTRIES];
    logic             uncond_mem [ENTRIES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_index_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i && !rst_i) begin
            tag_mem[wr_index_i]    <= wr_tag_i;
            target_mem[wr_index_i] <= wr_target_i;
            uncond_mem[wr_index_i] <= wr_uncond_i;
        end
    end

    assign rd_hit_o    = valid_q[rd_index_i] && (tag_mem[rd_index_i] == rd_tag_i);
    assign rd_uncond_o = uncond_mem[rd_index_i];
    assign rd_target_o = target_mem[rd_index_i];

endmodule

// File: rtl/gshare_predictor_pht.sv
// gshare_predictor_pht
// Pattern history table of saturating counters plus the global history register.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (counters weakly
//                     not-taken, history cleared)
//   if_index_i        Fetch PC index field
//   pht_index_o       table index used for this lookup (hashed with GHR or not)
//   ctr_msb_o         direction bit of the addressed counter
//   upd_en_i          conditional branch commit
//   upd_index_i       index captured at fetch time for the committing branch
//   upd_taken_i       resolved direction
// History is updated at commit only, so the fetch index and the carried
// update index can differ if other branches committed in between.
module gshare_predictor_pht
    import gshare_predictor_pkg::*;
#(
    parameter int INDEX_WIDTH = 12,
    parameter int CTR_WIDTH   = 2,
    parameter int HIST_WIDTH  = 8,
    parameter bit GSHARE_EN   = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [INDEX_WIDTH-1:0] if_index_i,
    output logic [INDEX_WIDTH-1:0] pht_index_o,
    output logic                   ctr_msb_o,
    input  logic                   upd_en_i,
    input  logic [INDEX_WIDTH-1:0] upd_index_i,
    input  logic                   upd_taken_i
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_RESET = CTR_WIDTH'(ctr_init(CTR_WIDTH));

    logic [ENTRIES-1:0][CTR_WIDTH-1:0] ctr_q;
    logic [ENTRIES-1:0][CTR_WIDTH-1:0] ctr_d;
    logic [HIST_WIDTH-1:0]             ghr_q;
    logic [HIST_WIDTH-1:0]             ghr_d;
    logic [INDEX_WIDTH-1:0]            ghr_ext;
    logic [CTR_WIDTH-1:0]              upd_ctr;

    always_comb begin
        ghr_ext = '0;
        ghr_ext[HIST_WIDTH-1:0] = ghr_q;
        pht_index_o = GSHARE_EN ? (if_index_i ^ ghr_ext) : if_index_i;
    end

    assign ctr_msb_o = ctr_q[pht_index_o][CTR_WIDTH-1];

    always_comb begin
        upd_ctr = CTR_WIDTH'(ctr_sat_step(ctr_t'(ctr_q[upd_index_i]), upd_taken_i, CTR_WIDTH));
        ctr_d   = ctr_q;
        ghr_d   = ghr_q;
        if (upd_en_i) begin
            ctr_d[upd_index_i] = upd_ctr;
            // Shift left, newest outcome enters at bit 0; the cast drops the oldest bit.
            ghr_d = HIST_WIDTH'({ghr_q, upd_taken_i});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctr_q <= {ENTRIES{CTR_RESET}};
            ghr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
            ghr_q <= ghr_d;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor
// Dynamic branch predictor for Fetch: tagged BTB + PHT (bimodal or gshare).
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   bus     gshare_predictor_if.slave: IF lookup in, EXMEM commit in,
//           hit/prediction/target, PCnext select and flush out
// This level holds only the prediction combine and the PCnext decoder;
// storage lives in the btb and pht sub-modules.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int INDEX_WIDTH = 12,
    parameter int CTR_WIDTH   = 2,
    parameter int HIST_WIDTH  = 8,
    parameter bit GSHARE_EN   = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    gshare_predictor_if.slave     bus
);
    logic        commit;
    logic        btb_hit;
    logic        btb_uncond;
    logic [31:0] btb_target;
    logic        ctr_msb;
    logic        pred_taken;
    logic        flush;
    pcnext_sel_e pcnext_sel;

    assign commit = bus.EXMEM_valid & bus.EXMEM_is_jmp;

    gshare_predictor_btb #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_btb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_index_i  (bus.IF_btb_rd_index),
        .rd_tag_i    (bus.IF_PC_tag),
        .rd_hit_o    (btb_hit),
        .rd_uncond_o (btb_uncond),
        .rd_target_o (btb_target),
        .wr_en_i     (commit & bus.EXMEM_br_decision),
        .wr_index_i  (bus.EXMEM_btb_wr_index),
        .wr_tag_i    (bus.EXMEM_btb_wr_tag),
        .wr_target_i (bus.EXMEM_btb_wr_target),
        .wr_uncond_i (bus.EXMEM_is_uncond)
    );

    gshare_predictor_pht #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .CTR_WIDTH   (CTR_WIDTH),
        .HIST_WIDTH  (HIST_WIDTH),
        .GSHARE_EN   (GSHARE_EN)
    ) u_pht (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_index_i  (bus.IF_btb_rd_index),
        .pht_index_o (bus.IF_pht_index),
        .ctr_msb_o   (ctr_msb),
        .upd_en_i    (commit & ~bus.EXMEM_is_uncond),
        .upd_index_i (bus.EXMEM_pht_index),
        .upd_taken_i (bus.EXMEM_br_decision)
    );

    // Jumps always redirect on a hit; conditional branches follow the counter.
    assign pred_taken = btb_hit & (btb_uncond | ctr_msb);

    // A committing mispredict overrides the Fetch-side choice.
    always_comb begin
        pcnext_sel = pred_taken ? BTB_TGT : PC4_IF;
        flush      = 1'b0;
        if (commit) begin
            if (bus.EXMEM_pred_taken && !bus.EXMEM_br_decision) begin
                pcnext_sel = PC4_EXMEM;
                flush      = 1'b1;
            end else if (!bus.EXMEM_pred_taken && bus.EXMEM_br_decision) begin
                pcnext_sel = BR_TGT;
                flush      = 1'b1;
            end else if (bus.EXMEM_pred_taken && bus.EXMEM_br_decision &&
                         (bus.EXMEM_pred_target != bus.EXMEM_btb_wr_target)) begin
                // Taken as predicted but to a different place (JALR retarget).
                pcnext_sel = BR_TGT;
                flush      = 1'b1;
            end
        end
    end

    assign bus.IF_btb_hit       = btb_hit;
    assign bus.IF_pred_taken    = pred_taken;
    assign bus.IF_btb_rd_target = btb_target;
    assign bus.IF_PCnext_sel    = pcnext_sel;
    assign bus.IF_flush         = flush;

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;
    import gshare_predictor_pkg::*;

    localparam int IW = 12;
    localparam int TW = 32 - IW - 2;
    localparam int HW = 4;
    localparam int NE = 1 << IW;
    localparam logic [IW-1:0] IDLE_IDX = 12'h7FF;
    localparam logic [TW-1:0] IDLE_TAG = '1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gshare_predictor_if #(.INDEX_WIDTH(IW)) bus_a ();
    gshare_predictor_if #(.INDEX_WIDTH(IW)) bus_b ();

    // dut_a: gshare, dut_b: bimodal
    gshare_predictor #(.INDEX_WIDTH(IW), .CTR_WIDTH(2), .HIST_WIDTH(HW), .GSHARE_EN(1'b1))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
    gshare_predictor #(.INDEX_WIDTH(IW), .CTR_WIDTH(2), .HIST_WIDTH(HW), .GSHARE_EN(1'b0))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Stimulus state
    logic [IW-1:0] f_idx;
    logic [TW-1:0] f_tag;
    logic          c_valid, c_jmp, c_unc, c_dec;
    logic [IW-1:0] c_widx;
    logic [TW-1:0] c_wtag;
    logic [31:0]   c_wtgt;
    logic          c_ptaken [2];
    logic [31:0]   c_ptgt   [2];
    logic [IW-1:0] c_phtidx [2];

    // Reference model, index 0 = gshare, 1 = bimodal
    bit            m_valid [2][NE];
    logic [TW-1:0] m_tag   [2][NE];
    logic [31:0]   m_tgt   [2][NE];
    bit            m_unc   [2][NE];
    logic [1:0]    m_ctr   [2][NE];
    logic [HW-1:0] m_ghr   [2];

    typedef struct {
        int            d;
        logic          hit;
        logic          pred;
        logic [IW-1:0] pidx;
        logic [31:0]   tgt;
        logic [1:0]    sel;
        logic          flush;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t m_expect(int d);
        exp_t e;
        logic c;
        e.d     = d;
        e.pidx  = (d == 0) ? (f_idx ^ IW'(m_ghr[d])) : f_idx;
        e.hit   = m_valid[d][f_idx] && (m_tag[d][f_idx] == f_tag);
        e.tgt   = e.hit ? m_tgt[d][f_idx] : 32'h0;
        e.pred  = e.hit && (m_unc[d][f_idx] || m_ctr[d][e.pidx][1]);
        e.sel   = e.pred ? 2'b10 : 2'b00;
        e.flush = 1'b0;
        c = c_valid && c_jmp;
        if (c && c_ptaken[d] && !c_dec) begin
            e.sel = 2'b01; e.flush = 1'b1;
        end else if (c && !c_ptaken[d] && c_dec) begin
            e.sel = 2'b11; e.flush = 1'b1;
        end else if (c && c_ptaken[d] && c_dec && (c_ptgt[d] != c_wtgt)) begin
            e.sel = 2'b11; e.flush = 1'b1;
        end
        return e;
    endfunction

    task automatic m_update();
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_ghr[d] = '0;
                for (int i = 0; i < NE; i++) begin
                    m_valid[d][i] = 1'b0;
                    m_ctr[d][i]   = 2'd1;
                end
            end
        end else if (c_valid && c_jmp) begin
            for (int d = 0; d < 2; d++) begin
                if (c_dec) begin
                    m_valid[d][c_widx] = 1'b1;
                    m_tag[d][c_widx]   = c_wtag;
                    m_tgt[d][c_widx]   = c_wtgt;
                    m_unc[d][c_widx]   = c_unc;
                end
                if (!c_unc) begin
                    if (c_dec && m_ctr[d][c_phtidx[d]] != 2'd3)
                        m_ctr[d][c_phtidx[d]] = m_ctr[d][c_phtidx[d]] + 2'd1;
                    else if (!c_dec && m_ctr[d][c_phtidx[d]] != 2'd0)
                        m_ctr[d][c_phtidx[d]] = m_ctr[d][c_phtidx[d]] - 2'd1;
                    m_ghr[d] = {m_ghr[d][HW-2:0], c_dec};
                end
            end
        end
    endtask

    task automatic drive();
        bus_a.IF_PC_tag           = f_tag;     bus_b.IF_PC_tag           = f_tag;
        bus_a.IF_btb_rd_index     = f_idx;     bus_b.IF_btb_rd_index     = f_idx;
        bus_a.EXMEM_valid         = c_valid;   bus_b.EXMEM_valid         = c_valid;
        bus_a.EXMEM_is_jmp        = c_jmp;     bus_b.EXMEM_is_jmp        = c_jmp;
        bus_a.EXMEM_is_uncond     = c_unc;     bus_b.EXMEM_is_uncond     = c_unc;
        bus_a.EXMEM_br_decision   = c_dec;     bus_b.EXMEM_br_decision   = c_dec;
        bus_a.EXMEM_btb_wr_index  = c_widx;    bus_b.EXMEM_btb_wr_index  = c_widx;
        bus_a.EXMEM_btb_wr_tag    = c_wtag;    bus_b.EXMEM_btb_wr_tag    = c_wtag;
        bus_a.EXMEM_btb_wr_target = c_wtgt;    bus_b.EXMEM_btb_wr_target = c_wtgt;
        bus_a.EXMEM_pred_taken    = c_ptaken[0]; bus_b.EXMEM_pred_taken  = c_ptaken[1];
        bus_a.EXMEM_pred_target   = c_ptgt[0];   bus_b.EXMEM_pred_target = c_ptgt[1];
        bus_a.EXMEM_pht_index     = c_phtidx[0]; bus_b.EXMEM_pht_index   = c_phtidx[1];
    endtask

    task automatic idle_exmem();
        c_valid = 1'b0; c_jmp = 1'b0; c_unc = 1'b0; c_dec = 1'b0;
        c_widx = '0; c_wtag = '0; c_wtgt = '0;
        for (int d = 0; d < 2; d++) begin
            c_ptaken[d] = 1'b0; c_ptgt[d] = '0; c_phtidx[d] = '0;
        end
    endtask

    task automatic compare(input exp_t e);
        string n;
        n = (e.d == 0) ? "A" : "B";
        if (e.d == 0) begin
            check_val({n, ".hit"},   32'(bus_a.IF_btb_hit),    32'(e.hit));
            check_val({n, ".pred"},  32'(bus_a.IF_pred_taken), 32'(e.pred));
            check_val({n, ".pidx"},  32'(bus_a.IF_pht_index),  32'(e.pidx));
            check_val({n, ".sel"},   32'(bus_a.IF_PCnext_sel), 32'(e.sel));
            check_val({n, ".flush"}, 32'(bus_a.IF_flush),      32'(e.flush));
            if (e.hit) check_val({n, ".tgt"}, bus_a.IF_btb_rd_target, e.tgt);
        end else begin
            check_val({n, ".hit"},   32'(bus_b.IF_btb_hit),    32'(e.hit));
            check_val({n, ".pred"},  32'(bus_b.IF_pred_taken), 32'(e.pred));
            check_val({n, ".pidx"},  32'(bus_b.IF_pht_index),  32'(e.pidx));
            check_val({n, ".sel"},   32'(bus_b.IF_PCnext_sel), 32'(e.sel));
            check_val({n, ".flush"}, 32'(bus_b.IF_flush),      32'(e.flush));
            if (e.hit) check_val({n, ".tgt"}, bus_b.IF_btb_rd_target, e.tgt);
        end
    endtask

    // One cycle: drive, predict, compare, then advance past the clock edge.
    task automatic step();
        exp_t e;
        drive();
        #2;
        if (!rst) begin
            sb.push_back(m_expect(0));
            sb.push_back(m_expect(1));
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            compare(e);
        end
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_exmem();
        f_idx = IDLE_IDX; f_tag = IDLE_TAG;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_fetch(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
        exp_t e;
        f_idx = idx; f_tag = tag;
        for (int d = 0; d < 2; d++) begin
            e = m_expect(d);
            c_ptaken[d] = e.pred; c_ptgt[d] = e.tgt; c_phtidx[d] = e.pidx;
        end
        drive();
        #1;
    endtask

    // Fetch cycle followed by the commit of that branch, prediction carried down.
    task automatic run_branch(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                              input logic unc, input logic dec, input logic [31:0] tgt);
        idle_exmem();
        set_fetch(idx, tag);
        step();
        f_idx = IDLE_IDX; f_tag = IDLE_TAG;
        c_valid = 1'b1; c_jmp = 1'b1; c_unc = unc; c_dec = dec;
        c_widx = idx; c_wtag = tag; c_wtgt = tgt;
        step();
        idle_exmem();
    endtask

    logic [IW-1:0] ridx [4];

    initial begin
        ridx[0] = 12'h005; ridx[1] = 12'h006; ridx[2] = 12'h015; ridx[3] = 12'h025;
        do_reset();

        // Reset state with idle inputs
        f_idx = 12'h123; f_tag = 18'h00042;
        drive(); #1;
        check_val("rst.hit",  32'(bus_a.IF_btb_hit), 32'd0);
        check_val("rst.pidx", 32'(bus_a.IF_pht_index), 32'h123);
        check_val("rst.sel",  32'(bus_b.IF_PCnext_sel), 32'(PC4_IF));
        check_val("rst.flush", 32'(bus_b.IF_flush), 32'd0);
        step();

        // Global history: T,T,N,T -> 4'b1101
        run_branch(12'h020, 18'h1, 1'b0, 1'b1, 32'h400);
        run_branch(12'h020, 18'h1, 1'b0, 1'b1, 32'h400);
        run_branch(12'h020, 18'h1, 1'b0, 1'b0, 32'h400);
        run_branch(12'h020, 18'h1, 1'b0, 1'b1, 32'h400);
        set_fetch(12'h00F, 18'h2);
        check_val("ghr.pidx_gshare",  32'(bus_a.IF_pht_index), 32'h002);
        check_val("ghr.pidx_bimodal", 32'(bus_b.IF_pht_index), 32'h00F);
        step();

        // Counter saturation at index 5
        do_reset();
        repeat (3) run_branch(12'h005, 18'h123, 1'b0, 1'b1, 32'h1000);
        set_fetch(12'h005, 18'h123);
        check_val("sat.pred", 32'(bus_b.IF_pred_taken), 32'd1);
        check_val("sat.sel",  32'(bus_b.IF_PCnext_sel), 32'(BTB_TGT));
        step();
        repeat (4) run_branch(12'h005, 18'h123, 1'b0, 1'b0, 32'h1000);
        repeat (2) run_branch(12'h005, 18'h123, 1'b0, 1'b1, 32'h1000);

        // JAL: predicted taken through the uncond bit, history untouched
        run_branch(12'h009, 18'h55, 1'b1, 1'b1, 32'h2000);
        set_fetch(12'h009, 18'h55);
        step();

        // JALR retarget 0x100 -> 0x200
        run_branch(12'h00A, 18'h66, 1'b1, 1'b1, 32'h100);
        run_branch(12'h00A, 18'h66, 1'b1, 1'b1, 32'h200);
        set_fetch(12'h00A, 18'h66);
        check_val("jalr.tgt",  bus_a.IF_btb_rd_target, 32'h200);
        check_val("jalr.pred", 32'(bus_a.IF_pred_taken), 32'd1);
        step();

        // Mixed traffic
        for (int i = 0; i < 24; i++) begin
            run_branch(ridx[$urandom_range(0, 3)], ($urandom_range(0, 1) != 0) ? 18'h11 : 18'h22,
                       ($urandom_range(0, 3) == 0), $urandom_range(0, 1) != 0,
                       {$urandom_range(0, 255), 2'b00});
            set_fetch(ridx[$urandom_range(0, 3)], 18'h11);
            step();
        end

        // Reset with a commit pending: commit discarded
        idle_exmem();
        set_fetch(12'h030, 18'h77);
        step();
        rst = 1'b1;
        f_idx = IDLE_IDX; f_tag = IDLE_TAG;
        c_valid = 1'b1; c_jmp = 1'b1; c_unc = 1'b0; c_dec = 1'b1;
        c_widx = 12'h030; c_wtag = 18'h77; c_wtgt = 32'h3000;
        step();
        rst = 1'b0;
        idle_exmem();
        set_fetch(12'h030, 18'h77);
        check_val("rstc.hit",   32'(bus_a.IF_btb_hit), 32'd0);
        check_val("rstc.pidx",  32'(bus_a.IF_pht_index), 32'h030);
        check_val("rstc.sel",   32'(bus_a.IF_PCnext_sel), 32'(PC4_IF));
        check_val("rstc.flush", 32'(bus_a.IF_flush), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
